// File: rtl/inst_sequencer_if.sv
// rtl/inst_sequencer_if.sv - host push channel and coprocessor issue bus of the instruction sequencer
interface inst_sequencer_if;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        done;
    logic [7:0]  instruction;
    logic        modulus_sel;
    logic [3:0]  rdM0;
    logic [3:0]  rdM1;
    logic [3:0]  wtM0;
    logic [3:0]  wtM1;

    // master: the sequencer itself; slave: host plus coprocessor side
    modport master (
        input  push_valid, push_data, done,
        output push_ready, instruction, modulus_sel, rdM0, rdM1, wtM0, wtM1
    );
    modport slave (
        output push_valid, push_data, done,
        input  push_ready, instruction, modulus_sel, rdM0, rdM1, wtM0, wtM1
    );
endinterface

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction FIFO and one-at-a-time issue controller for the HE coprocessor
module inst_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                     bram_clk_a,
    input  logic                     bram_rst_a,
    inst_sequencer_if.master         bus,
    input  logic                     run,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     idle,
    output logic [15:0]              issued_cnt,
    output logic                     err_overflow,
    output logic                     err_timeout
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_HALT} state_t;

    state_t        r_state, w_state_next;
    // word[15:9] carries nothing the coprocessor sees, so it is not stored
    logic [24:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic [24:0]   r_word;
    logic [31:0]   r_wdog;
    logic [15:0]   r_issued_cnt;
    logic          r_err_overflow, r_err_timeout;

    logic          w_full, w_empty, w_push, w_pop, w_load;
    logic          w_done_issue, w_fault, w_timeout;
    logic [24:0]   w_head;
    logic [31:0]   w_wdog_inc;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign bus.push_ready = !w_full && !flush;
    assign w_push     = bus.push_valid && bus.push_ready;
    // a flush in the same cycle wins, so the pop is simply suppressed
    assign w_pop      = (r_state == S_IDLE) && !w_empty && run && !bus.done && !flush;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_load     = w_pop && (w_head[7:0] != 8'd0);
    assign w_wdog_inc = r_wdog + 32'd1;
    assign w_timeout  = (TIMEOUT != 0) && (w_wdog_inc == 32'(TIMEOUT));
    assign w_done_issue = (r_state == S_ISSUE) && bus.done;
    assign w_fault      = (r_state == S_ISSUE) && !bus.done && w_timeout;

    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_load) w_state_next = S_ISSUE;
            S_ISSUE: begin
                if (bus.done)       w_state_next = S_RELEASE;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_RELEASE: if (!bus.done) w_state_next = S_IDLE;
            S_HALT:    if (flush)     w_state_next = S_RELEASE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge bram_clk_a) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.push_data[31:16], bus.push_data[8:0]};
    end

    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_word <= '0;
            r_wdog <= '0;
        end else begin
            if (w_load)                        r_word <= w_head;
            else if (w_done_issue || w_fault)  r_word <= '0;
            if (w_load)                        r_wdog <= '0;
            else if (r_state == S_ISSUE)       r_wdog <= w_wdog_inc;
        end
    end

    always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
        if (bram_rst_a) begin
            r_issued_cnt   <= '0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (w_done_issue) r_issued_cnt <= r_issued_cnt + 16'd1;
            if (flush)                                    r_err_overflow <= 1'b0;
            else if (bus.push_valid && !bus.push_ready)   r_err_overflow <= 1'b1;
            // a fault on the flush edge still leaves the flag set so HALT is never silent
            if (w_fault)    r_err_timeout <= 1'b1;
            else if (flush) r_err_timeout <= 1'b0;
        end
    end

    assign bus.instruction = r_word[7:0];
    assign bus.modulus_sel = r_word[8];
    assign bus.rdM0        = r_word[12:9];
    assign bus.rdM1        = r_word[16:13];
    assign bus.wtM0        = r_word[20:17];
    assign bus.wtM1        = r_word[24:21];

    assign level        = r_wr_ptr - r_rd_ptr;
    assign busy         = (r_state == S_ISSUE) || (r_state == S_RELEASE);
    assign idle         = (r_state == S_IDLE) && (level == '0);
    assign issued_cnt   = r_issued_cnt;
    assign err_overflow = r_err_overflow;
    assign err_timeout  = r_err_timeout;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - randomized self-checking bench for inst_sequencer
module tb_inst_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam logic [31:0] MASK = 32'hFFFF_01FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  level;
    logic        busy, idle, err_ov, err_to;
    logic [15:0] issued_cnt;

    inst_sequencer_if sif ();

    inst_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .bram_clk_a   (clk),
        .bram_rst_a   (rst),
        .bus          (sif),
        .run          (run),
        .flush        (flush),
        .level        (level),
        .busy         (busy),
        .idle         (idle),
        .issued_cnt   (issued_cnt),
        .err_overflow (err_ov),
        .err_timeout  (err_to)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // reference model: words accepted into the queue in push order, completions expected
    logic [31:0] q[$];
    int          exp_cnt = 0;
    bit          exp_ov  = 0;
    bit          cop_en  = 1;
    bit          cop_rand = 0;
    int          cop_lat = 3;
    int          cop_rel = 2;

    function automatic logic [31:0] bus_word();
        return {sif.wtM1, sif.wtM0, sif.rdM1, sif.rdM0, 7'd0, sif.modulus_sel, sif.instruction};
    endfunction

    // coprocessor: raise done after cop_lat busy cycles, drop it cop_rel cycles after the bus clears
    initial begin
        int cnt = 0;
        int rc = 0;
        sif.done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sif.done = 1'b0; cnt = 0; rc = 0;
            end else if (!sif.done) begin
                if (cop_en && sif.instruction != 8'd0) begin
                    cnt++;
                    if (cnt >= cop_lat) begin sif.done = 1'b1; cnt = 0; rc = 0; end
                end
            end else if (sif.instruction == 8'd0) begin
                rc++;
                if (rc >= cop_rel) begin
                    sif.done = 1'b0;
                    if (cop_rand) begin
                        cop_lat = $urandom_range(1, 7);
                        cop_rel = $urandom_range(1, 3);
                    end
                end
            end
        end
    end

    // bus monitor: order, stability while held, and zero gap between instructions
    initial begin
        bit prev_nz = 0;
        bit first = 1;
        int zrun = 0;
        logic [31:0] cur, held, w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_nz = 0; first = 1; zrun = 0;
            end else begin
                cur = bus_word();
                if (cur != 32'd0) begin
                    if (!prev_nz) begin
                        while (q.size() > 0 && q[0][7:0] == 8'd0) void'(q.pop_front());
                        if (q.size() == 0) check("unexpected_issue", cur, 32'd0);
                        else begin
                            w = q.pop_front();
                            check("issue_word", cur, w & MASK);
                        end
                        if (!first) check("issue_gap_ge2", 32'(zrun >= 2), 32'd1);
                        first = 0;
                        if (cop_en) exp_cnt++;
                        held = cur;
                    end else begin
                        check("hold_word", cur, held);
                    end
                    zrun = 0; prev_nz = 1;
                end else begin
                    zrun++; prev_nz = 0;
                end
            end
        end
    end

    task automatic push(input logic [31:0] w);
        bit acc;
        @(negedge clk);
        sif.push_valid = 1'b1;
        sif.push_data  = w;
        acc = (q.size() < DEPTH);
        check("push_ready", 32'(sif.push_ready), 32'(acc));
        @(posedge clk); #1;
        sif.push_valid = 1'b0;
        if (acc) q.push_back(w); else exp_ov = 1;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        q.delete();
        exp_ov = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!(idle && !sif.done) && k < 3000) begin @(negedge clk); k++; end
        check("wait_idle_bound", 32'(k < 3000), 32'd1);
    endtask

    task automatic wait_bus();
        int k = 0;
        while (sif.instruction == 8'd0 && k < 50) begin @(posedge clk); #1; k++; end
        check("wait_bus_bound", 32'(k < 50), 32'd1);
    endtask

    function automatic logic [31:0] rnd_word(input bit allow_nop);
        logic [31:0] w;
        w = $urandom;
        if (allow_nop && $urandom_range(0, 3) == 0) w[7:0] = 8'd0;
        else w[7:0] = 8'($urandom_range(1, 255));
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, c0, k;
        sif.push_valid = 1'b0;
        sif.push_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_cnt", 32'(issued_cnt), 32'd0);
        check("rst_errs", 32'({err_ov, err_to}), 32'd0);
        check("rst_bus", bus_word(), 32'd0);
        check("rst_push_ready", 32'(sif.push_ready), 32'd1);
        @(negedge clk); rst = 1'b0;

        // single issue with push-to-bus latency
        @(negedge clk); run = 1'b1;
        push(32'h1234_0105);
        check("lat_zero_at_push_edge", bus_word(), 32'd0);
        @(posedge clk); #1;
        check("single_inst", 32'(sif.instruction), 32'h05);
        check("single_mod", 32'(sif.modulus_sel), 32'd1);
        check("single_rdM0", 32'(sif.rdM0), 32'd4);
        check("single_rdM1", 32'(sif.rdM1), 32'd3);
        check("single_wtM0", 32'(sif.wtM0), 32'd2);
        check("single_wtM1", 32'(sif.wtM1), 32'd1);
        n = 0;
        while (sif.instruction != 8'd0 && n < 20) begin n++; @(posedge clk); #1; end
        check("single_width", 32'(n), 32'd3);
        wait_idle();
        check("single_cnt", 32'(issued_cnt), 32'd1);
        check("single_idle", 32'(idle), 32'd1);

        // burst with NOP and pause
        @(negedge clk); run = 1'b0;
        push(32'h0000_0001); push(32'h0000_0000); push(32'h0000_0002);
        check("burst_level", 32'(level), 32'd3);
        repeat (4) @(negedge clk);
        check("burst_paused_bus", bus_word(), 32'd0);
        c0 = 32'(issued_cnt);
        @(negedge clk); run = 1'b1;
        wait_idle();
        check("burst_cnt", 32'(issued_cnt), 32'(c0 + 2));

        // overflow and wrap
        @(negedge clk); run = 1'b0;
        for (int i = 0; i < 5; i++) push(rnd_word(0));
        check("ovf_flag", 32'(err_ov), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        c0 = 32'(issued_cnt);
        @(negedge clk); run = 1'b1;
        wait_idle();
        check("ovf_cnt", 32'(issued_cnt), 32'(c0 + 4));
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); run = 1'b0;
            for (int i = 0; i < 3; i++) push(rnd_word(0));
            @(negedge clk); run = 1'b1;
            wait_idle();
        end
        check("wrap_cnt", 32'(issued_cnt), 32'(c0 + 10));
        do_flush();
        check("flush_clears_ovf", 32'(err_ov), 32'd0);

        // randomized rounds against the model
        cop_rand = 1;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk); run = 1'b0;
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) push(rnd_word(1));
            check("rnd_level", 32'(level), 32'(q.size()));
            check("rnd_ovf", 32'(err_ov), 32'(exp_ov));
            @(negedge clk); run = 1'b1;
            wait_idle();
            check("rnd_cnt", 32'(issued_cnt), 32'(exp_cnt[15:0]));
            check("rnd_drained", 32'(level), 32'd0);
            while (q.size() > 0 && q[0][7:0] == 8'd0) void'(q.pop_front());
            check("rnd_unissued", 32'(q.size()), 32'd0);
            do_flush();
        end
        cop_rand = 0; cop_lat = 3; cop_rel = 2;

        // timeout and recovery
        @(negedge clk); cop_en = 0; run = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_word(0));
        @(negedge clk); run = 1'b1;
        wait_bus();
        n = 0;
        while (sif.instruction != 8'd0 && n < 30) begin n++; @(posedge clk); #1; end
        check("to_width", 32'(n), 32'(TIMEOUT));
        check("to_flag", 32'(err_to), 32'd1);
        check("to_level", 32'(level), 32'd2);
        check("to_halt_not_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("to_no_pop", 32'(level), 32'd2);
        check("to_bus_zero", bus_word(), 32'd0);
        do_flush();
        check("to_flush_level", 32'(level), 32'd0);
        check("to_flush_errs", 32'({err_ov, err_to}), 32'd0);
        cop_en = 1;
        wait_idle();
        check("to_idle", 32'(idle), 32'd1);

        // flush during ISSUE
        cop_lat = 5;
        c0 = 32'(issued_cnt);
        @(negedge clk); run = 1'b0;
        for (int i = 0; i < 4; i++) push(rnd_word(0));
        @(negedge clk); run = 1'b1;
        wait_bus();
        do_flush();
        check("fl_issue_still_busy", 32'(busy), 32'd1);
        wait_idle();
        check("fl_cnt", 32'(issued_cnt), 32'(c0 + 1));
        check("fl_level", 32'(level), 32'd0);

        // asynchronous reset while in ISSUE
        @(negedge clk); cop_en = 0; run = 1'b0;
        push(rnd_word(0));
        @(negedge clk); run = 1'b1;
        wait_bus();
        #2 rst = 1'b1;
        #1;
        check("arst_bus", bus_word(), 32'd0);
        check("arst_cnt", 32'(issued_cnt), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        q.delete(); exp_cnt = 0; exp_ov = 0;
        @(negedge clk); rst = 1'b0; cop_en = 1; cop_lat = 2;
        push(32'h8765_01AA);
        wait_idle();
        check("post_rst_cnt", 32'(issued_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
